// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide engine for the execute stage.
// Handles MULT/MULTU/DIV/DIVU with a start/ready handshake, mid-operation
// annul and divide-by-zero reporting. The 2*WIDTH result feeds HI/LO.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start_i         request; sampled only while busy_o == 0
//   op_i            00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a_i, b_i        multiplicand/dividend, multiplier/divisor
//   annul_i         abort the in-flight operation (wins over start_i)
//   busy_o          operation in flight; start_i ignored
//   ready_o         one-cycle pulse, result_o/div_by_zero_o valid
//   result_o        MUL: full product; DIV: {remainder, quotient}
//   div_by_zero_o   divisor was zero (valid with ready_o)
module muldiv_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_by_zero_o
);

  localparam int unsigned CntW    = ($clog2(WIDTH) > 2) ? $clog2(WIDTH) : 2;
  localparam int unsigned MulLast = (MUL_STAGES > 1) ? MUL_STAGES - 2 : 0;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDivPrep,
    StDivIter,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;      // multiplicand, later dividend/quotient shift reg
  logic [WIDTH-1:0]     b_q, b_d;      // multiplier, later divisor magnitude
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 sgn_q, sgn_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 dbz_q, dbz_d;

  logic                 accept;
  logic                 sgn_i;
  logic                 mul_last;
  logic                 div_last;

  // Multiply datapath: operands come straight from the ports when the
  // product must be ready on the sampling edge (single-stage multiply).
  logic [WIDTH-1:0]     mul_a, mul_b, mag_a, mag_b;
  logic                 mul_sgn, mul_neg;
  logic [2*WIDTH-1:0]   prod_mag, prod_fix;

  // Restoring divide step.
  logic [WIDTH:0]       shifted, diff;
  logic                 qbit;
  logic [WIDTH-1:0]     rem_nxt, quo_nxt, q_fix, r_fix;

  assign sgn_i    = ~op_i[0];
  assign accept   = start_i & ~annul_i & ((state_q == StIdle) | (state_q == StDone));
  assign mul_last = (cnt_q == CntW'(MulLast));
  assign div_last = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    mul_a    = (state_q == StMul) ? a_q : a_i;
    mul_b    = (state_q == StMul) ? b_q : b_i;
    mul_sgn  = (state_q == StMul) ? sgn_q : sgn_i;
    mag_a    = (mul_sgn & mul_a[WIDTH-1]) ? -mul_a : mul_a;
    mag_b    = (mul_sgn & mul_b[WIDTH-1]) ? -mul_b : mul_b;
    mul_neg  = mul_sgn & (mul_a[WIDTH-1] ^ mul_b[WIDTH-1]);
    prod_mag = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
    prod_fix = mul_neg ? -prod_mag : prod_mag;
  end

  always_comb begin
    shifted = {rem_q, a_q[WIDTH-1]};
    diff    = shifted - {1'b0, b_q};
    qbit    = ~diff[WIDTH];
    rem_nxt = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nxt = {a_q[WIDTH-2:0], qbit};
    q_fix   = qneg_q ? -quo_nxt : quo_nxt;
    r_fix   = rneg_q ? -rem_nxt : rem_nxt;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      sgn_q    <= sgn_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          if (!op_i[1]) begin
            state_d = (MUL_STAGES <= 1) ? StDone : StMul;
          end else if (b_i == '0) begin
            state_d = StDone;
          end else begin
            state_d = StDivPrep;
          end
        end
      end
      StMul: begin
        if (annul_i)       state_d = StIdle;
        else if (mul_last) state_d = StDone;
      end
      StDivPrep: begin
        state_d = annul_i ? StIdle : StDivIter;
      end
      StDivIter: begin
        if (annul_i)       state_d = StIdle;
        else if (div_last) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values; result only moves on a transition into StDone.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    sgn_d    = sgn_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          a_d    = a_i;
          b_d    = b_i;
          sgn_d  = sgn_i;
          qneg_d = sgn_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          rneg_d = sgn_i & a_i[WIDTH-1];
          cnt_d  = '0;
          if (!op_i[1] && (MUL_STAGES <= 1)) begin
            result_d = prod_fix;
            dbz_d    = 1'b0;
          end else if (op_i[1] && (b_i == '0)) begin
            result_d = '0;
            dbz_d    = 1'b1;
          end
        end
      end
      StMul: begin
        cnt_d = cnt_q + CntW'(1);
        if (!annul_i && mul_last) begin
          result_d = prod_fix;
          dbz_d    = 1'b0;
        end
      end
      StDivPrep: begin
        a_d   = (sgn_q & a_q[WIDTH-1]) ? -a_q : a_q;
        b_d   = (sgn_q & b_q[WIDTH-1]) ? -b_q : b_q;
        rem_d = '0;
        cnt_d = '0;
      end
      StDivIter: begin
        a_d   = quo_nxt;
        rem_d = rem_nxt;
        cnt_d = cnt_q + CntW'(1);
        if (!annul_i && div_last) begin
          result_d = {r_fix, q_fix};
          dbz_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    busy_o        = (state_q == StMul) | (state_q == StDivPrep) | (state_q == StDivIter);
    ready_o       = (state_q == StDone);
    result_o      = result_q;
    div_by_zero_o = dbz_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [1:0] OpMult = 2'b00, OpMultu = 2'b01, OpDiv = 2'b10, OpDivu = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [1:0]    op_i;
  logic [W-1:0]  a_i, b_i;
  logic          annul_i;
  logic          busy_o, ready_o, div_by_zero_o;
  logic [2*W-1:0] result_o;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(W), .MUL_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .op_i         (op_i),
    .a_i          (a_i),
    .b_i          (b_i),
    .annul_i      (annul_i),
    .busy_o       (busy_o),
    .ready_o      (ready_o),
    .result_o     (result_o),
    .div_by_zero_o(div_by_zero_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] res;
    logic           dbz;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the operands. Returns {dbz, result}.
  function automatic logic [64:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = '0;
    case (op)
      OpMult:  begin q = sa * sb; res = q; end
      OpMultu: begin p = ua * ub; res = p; end
      OpDiv: begin
        if (b == 0) return {1'b1, 64'd0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, a};
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, 64'd0};
        p = ua / ub;
        res[31:0] = p[31:0];
        p = ua % ub;
        res[63:32] = p[31:0];
      end
    endcase
    return {1'b0, res};
  endfunction

  function automatic int exp_latency(input logic [1:0] op, input logic [W-1:0] b);
    if (!op[1]) return 2;
    if (b == 0) return 1;
    return W + 2;
  endfunction

  // Caller sits at a negedge; the next posedge samples the request.
  task automatic begin_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
  endtask

  // Called at the negedge after the sampling edge; returns at the negedge of the ready cycle.
  task automatic wait_ready(input int lat0, output int lat, output int busy_n);
    lat = lat0;
    busy_n = 0;
    while (!ready_o && lat < 200) begin
      if (busy_o) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no ready after %0d cycles, expected one", lat);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [63:0] exp_res, input logic exp_dbz);
    int lat, busy_n, elat;
    elat = exp_latency(op, b);
    @(negedge clk);
    begin_op(op, a, b);
    @(negedge clk);
    start_i = 1'b0;
    a_i = $urandom;  // later operand changes must not matter
    b_i = $urandom;
    wait_ready(1, lat, busy_n);
    check({name, "_latency"}, 64'(lat), 64'(elat));
    check({name, "_busy_cycles"}, 64'(busy_n), 64'(elat - 1));
    check({name, "_result"}, result_o, exp_res);
    check({name, "_dbz"}, 64'(div_by_zero_o), 64'(exp_dbz));
  endtask

  initial begin
    vec_t vecs[$];
    logic [64:0] m;
    logic [63:0] prev;
    logic [1:0] op;
    logic [W-1:0] a, b;
    int lat, busy_n;

    vecs.push_back('{OpMult,  32'hFFFF_FFFD, 32'd5,        64'hFFFF_FFFF_FFFF_FFF1, 1'b0});
    vecs.push_back('{OpDivu,  32'd100,       32'd7,        {32'd2, 32'd14},         1'b0});
    vecs.push_back('{OpDiv,   32'hFFFF_FFF9, 32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0});
    vecs.push_back('{OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0});
    vecs.push_back('{OpDivu,  32'd5,         32'd0,        64'd0,                   1'b1});
    vecs.push_back('{OpMultu, 32'd3,         32'd4,        64'd12,                  1'b0});
    vecs.push_back('{OpMultu, 32'hFFFF_FFFF, 32'd2,        64'h1_FFFF_FFFE,         1'b0});
    vecs.push_back('{OpDiv,   32'd7,         32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 1'b0});
    vecs.push_back('{OpMult,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0});
    vecs.push_back('{OpDiv,   32'd0,         32'd0,        64'd0,                   1'b1});
    vecs.push_back('{OpDivu,  32'hFFFF_FFFF, 32'd1,        {32'd0, 32'hFFFF_FFFF},  1'b0});

    rst = 1'b1; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0; annul_i = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_dbz", 64'(div_by_zero_o), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dbz);

    // Randomized ops against the model, with corner divisors mixed in.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = 32'hFFFF_FFFF;
        2: b = 1;
        3: a = 32'h8000_0000;
        4: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      m = model(op, a, b);
      run_op($sformatf("rand%0d", i), op, a, b, m[63:0], m[64]);
    end

    // start together with annul from idle is not accepted.
    @(negedge clk);
    begin_op(OpMultu, 32'd9, 32'd9);
    annul_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    check("annul_beats_start_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    check("annul_beats_start_ready", 64'(ready_o), 64'd0);

    // Annul on iteration 10 of a DIV.
    run_op("pre_annul", OpMultu, 32'd6, 32'd7, 64'd42, 1'b0);
    prev = result_o;
    @(negedge clk);
    begin_op(OpDiv, 32'd1000, 32'd3);
    @(negedge clk);           // cycle 1: prep
    start_i = 1'b0;
    repeat (11) @(negedge clk);  // cycle 12: iteration counter at 10
    check("annul_busy_before", 64'(busy_o), 64'd1);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul_busy_after", 64'(busy_o), 64'd0);
    check("annul_no_ready", 64'(ready_o), 64'd0);
    check("annul_result_held", result_o, prev);
    begin_op(OpMultu, 32'hFFFF_FFFF, 32'd2);
    @(negedge clk);
    start_i = 1'b0;
    wait_ready(1, lat, busy_n);
    check("post_annul_latency", 64'(lat), 64'd2);
    check("post_annul_result", result_o, 64'h1_FFFF_FFFE);

    // start mid-DIV with a different op is ignored.
    @(negedge clk);
    begin_op(OpDivu, 32'd1000, 32'd10);
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    begin_op(OpMultu, 32'd3, 32'd3);
    @(negedge clk);
    start_i = 1'b0;
    wait_ready(7, lat, busy_n);
    check("ignored_start_latency", 64'(lat), 64'(W + 2));
    check("ignored_start_result", result_o, {32'd0, 32'd100});
    @(negedge clk);
    check("ignored_start_no_second_ready", 64'(ready_o), 64'd0);

    // Back-to-back: new start accepted on the DONE cycle.
    run_op("b2b_first", OpMult, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b0);
    begin_op(OpDiv, 32'hFFFF_FF9C, 32'd7);  // -100 / 7
    @(negedge clk);
    start_i = 1'b0;
    wait_ready(1, lat, busy_n);
    check("b2b_latency", 64'(lat), 64'(W + 2));
    check("b2b_result", result_o, {32'hFFFF_FFFE, 32'hFFFF_FFF2});

    // Asynchronous reset in the middle of a DIV.
    @(negedge clk);
    begin_op(OpDivu, 32'd12345, 32'd67);
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy_o), 64'd0);
    check("async_rst_ready", 64'(ready_o), 64'd0);
    check("async_rst_result", result_o, 64'd0);
    check("async_rst_dbz", 64'(div_by_zero_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", OpDivu, 32'd12345, 32'd67, {32'd17, 32'd184}, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
